// File: rtl/mult_pkg.sv
// Shared constants for the shift-add multiplier datapath and its display path.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned NIBBLE        = 4;

  // Digit-select encoding {sel_1, sel_2}, least significant nibble first.
  localparam logic [1:0] DIG0 = 2'b00;
  localparam logic [1:0] DIG1 = 2'b01;
  localparam logic [1:0] DIG2 = 2'b10;
  localparam logic [1:0] DIG3 = 2'b11;

endpackage

// File: rtl/mult_datapath_if.sv
// Control-unit <-> multiplier datapath link: CU strobes out, status and result back.
interface mult_datapath_if
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic               clr;
  logic [WIDTH-1:0]   a_in;
  logic [WIDTH-1:0]   b_in;
  logic               load;
  logic               enable;
  logic               Psel;
  logic               sel_1;
  logic               sel_2;
  logic               done;
  logic               z_flag;
  logic               b0;
  logic [2*WIDTH-1:0] result;
  logic               result_valid;
  logic               sign;
  logic [3:0]         digit;

  modport master (
    output clr, a_in, b_in, load, enable, Psel, sel_1, sel_2, done,
    input  z_flag, b0, result, result_valid, sign, digit
  );

  modport slave (
    input  clr, a_in, b_in, load, enable, Psel, sel_1, sel_2, done,
    output z_flag, b0, result, result_valid, sign, digit
  );

endinterface

// File: rtl/nibble_mux.sv
// Selects one of four nibbles of a value; nibbles beyond the value's width read as zero.
module nibble_mux
  import mult_pkg::*;
#(
  parameter int unsigned DataWidth = 2 * DEFAULT_WIDTH
) (
  input  logic [DataWidth-1:0] data_i,
  input  logic [1:0]           sel_i,
  output logic [NIBBLE-1:0]    digit_o
);

  localparam int unsigned PadWidth = 4 * NIBBLE;

  // Zero-extend to the full four-nibble window so high selects fall on padding.
  logic [PadWidth-1:0] padded;

  always_comb begin
    padded  = PadWidth'(data_i);
    digit_o = padded[{sel_i, 2'b00} +: NIBBLE];
  end

endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath driven by the CU strobes over mult_datapath_if.
// Define MUL_SIGNED_EN for two's-complement operands with sign/magnitude correction.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  mult_datapath_if.slave  bus
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             sign_r_q, sign_r_d;
  logic             sign_q, sign_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             sign_load;
  logic [PW-1:0]    acc_fix;
  logic             sign_done;

`ifdef MUL_SIGNED_EN
  // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude.
  always_comb begin
    a_mag     = bus.a_in[WIDTH-1] ? (WIDTH'(0) - bus.a_in) : bus.a_in;
    b_mag     = bus.b_in[WIDTH-1] ? (WIDTH'(0) - bus.b_in) : bus.b_in;
    sign_load = bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1];
    acc_fix   = sign_r_q ? (PW'(0) - acc_q) : acc_q;
    sign_done = sign_r_q & (acc_q != '0);
  end
`else
  always_comb begin
    a_mag     = bus.a_in;
    b_mag     = bus.b_in;
    sign_load = 1'b0;
    acc_fix   = acc_q;
    sign_done = 1'b0;
  end
`endif

  always_comb begin
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    acc_d          = acc_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    sign_r_d       = sign_r_q;
    sign_d         = sign_q;
    if (bus.clr) begin
      mcand_d        = '0;
      mplier_d       = '0;
      acc_d          = '0;
      result_d       = '0;
      result_valid_d = 1'b0;
      sign_r_d       = 1'b0;
      sign_d         = 1'b0;
    end else if (bus.load) begin
      mcand_d        = {{WIDTH{1'b0}}, a_mag};
      mplier_d       = b_mag;
      acc_d          = '0;
      result_valid_d = 1'b0;
      sign_r_d       = sign_load;
    end else if (bus.enable) begin
      // An exhausted multiplier makes extra enables harmless idle steps.
      if (mplier_q != '0) begin
        acc_d    = acc_q + (bus.Psel ? mcand_q : '0);
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
      end
    end else if (bus.done) begin
      result_d       = acc_fix;
      result_valid_d = 1'b1;
      sign_d         = sign_done;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q        <= '0;
      mplier_q       <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      sign_r_q       <= 1'b0;
      sign_q         <= 1'b0;
    end else begin
      mcand_q        <= mcand_d;
      mplier_q       <= mplier_d;
      acc_q          <= acc_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      sign_r_q       <= sign_r_d;
      sign_q         <= sign_d;
    end
  end

  nibble_mux #(
    .DataWidth (PW)
  ) u_nibble_mux (
    .data_i  (result_q),
    .sel_i   ({bus.sel_1, bus.sel_2}),
    .digit_o (bus.digit)
  );

  assign bus.z_flag       = (mplier_q == '0);
  assign bus.b0           = mplier_q[0];
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.sign         = sign_q;

endmodule

// File: tb/tb_mult_datapath.sv
// Directed self-checking bench for mult_datapath (unsigned build, or signed with MUL_SIGNED_EN).
module tb_mult_datapath;
  import mult_pkg::*;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   steps;

  mult_datapath_if #(.WIDTH(W)) bus ();

  mult_datapath #(
    .WIDTH (W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [1:0] s);
    bus.sel_1 = s[1];
    bus.sel_2 = s[0];
    #1;
  endtask

  task automatic do_load(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.a_in = a;
    bus.b_in = b;
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic do_done();
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;
  endtask

  // Iterate as the CU would: Psel follows b0, stop on z_flag, bounded.
  task automatic run_iters(output int n);
    n = 0;
    while (!bus.z_flag && n < 2 * W) begin
      bus.enable = 1'b1;
      bus.Psel   = bus.b0;
      tick();
      bus.enable = 1'b0;
      bus.Psel   = 1'b0;
      n++;
    end
    if (!bus.z_flag) check_eq("iter_bound", 32'(bus.z_flag), 32'd1);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    bus.clr    = 1'b0;
    bus.a_in   = '0;
    bus.b_in   = '0;
    bus.load   = 1'b0;
    bus.enable = 1'b0;
    bus.Psel   = 1'b0;
    bus.sel_1  = 1'b0;
    bus.sel_2  = 1'b0;
    bus.done   = 1'b0;
    #12;
    check_eq("rst_z_flag", 32'(bus.z_flag), 32'd1);
    check_eq("rst_b0", 32'(bus.b0), 32'd0);
    check_eq("rst_result", 32'(bus.result), 32'd0);
    check_eq("rst_valid", 32'(bus.result_valid), 32'd0);
    check_eq("rst_sign", 32'(bus.sign), 32'd0);
    check_eq("rst_digit", 32'(bus.digit), 32'd0);
    rst = 1'b1;
    tick();

    // done with no prior load latches acc, which is 0
    do_done();
    check_eq("done_noload_result", 32'(bus.result), 32'd0);
    check_eq("done_noload_valid", 32'(bus.result_valid), 32'd1);

    // 13 x 11 = 143
    do_load(8'd13, 8'd11);
    check_eq("u13_load_z", 32'(bus.z_flag), 32'd0);
    check_eq("u13_load_b0", 32'(bus.b0), 32'd1);
    check_eq("u13_load_valid", 32'(bus.result_valid), 32'd0);
    run_iters(steps);
    check_eq("u13_steps", 32'(steps), 32'd4);
    do_done();
    check_eq("u13_result", 32'(bus.result), 32'h008F);
    check_eq("u13_valid", 32'(bus.result_valid), 32'd1);
    check_eq("u13_sign", 32'(bus.sign), 32'd0);

    set_sel(DIG0);
    check_eq("digit0", 32'(bus.digit), 32'hF);
    set_sel(DIG1);
    check_eq("digit1", 32'(bus.digit), 32'h8);
    set_sel(DIG2);
    check_eq("digit2", 32'(bus.digit), 32'h0);
    set_sel(DIG3);
    check_eq("digit3", 32'(bus.digit), 32'h0);
    set_sel(DIG0);

    // Abandon in-flight multiply; old result stays visible
    do_load(8'd7, 8'd6);
    bus.enable = 1'b1;
    bus.Psel   = 1'b0;
    tick();
    bus.enable = 1'b0;
    check_eq("abandon_mplier_b0", 32'(bus.b0), 32'd1);
    do_load(8'd9, 8'd5);
    check_eq("abandon_keep_result", 32'(bus.result), 32'h008F);
    run_iters(steps);
    do_done();
    check_eq("abandon_new_result", 32'(bus.result), 32'd45);

    // Zero multiplier and idle enables
    do_load(8'd200, 8'd0);
    check_eq("zero_z_flag", 32'(bus.z_flag), 32'd1);
    for (int i = 0; i < 3; i++) begin
      bus.enable = 1'b1;
      bus.Psel   = 1'b1;
      tick();
    end
    bus.enable = 1'b0;
    bus.Psel   = 1'b0;
    check_eq("zero_idle_z", 32'(bus.z_flag), 32'd1);
    do_done();
    check_eq("zero_result", 32'(bus.result), 32'd0);

    // load beats enable; mplier=5 stays unshifted so b0=1
    bus.a_in   = 8'd3;
    bus.b_in   = 8'd5;
    bus.load   = 1'b1;
    bus.enable = 1'b1;
    bus.Psel   = 1'b1;
    tick();
    bus.load   = 1'b0;
    bus.enable = 1'b0;
    bus.Psel   = 1'b0;
    check_eq("prio_load_b0", 32'(bus.b0), 32'd1);
    run_iters(steps);
    check_eq("prio_steps", 32'(steps), 32'd3);
    do_done();
    check_eq("prio_result", 32'(bus.result), 32'd15);

    // clr beats done
    bus.clr  = 1'b1;
    bus.done = 1'b1;
    tick();
    bus.clr  = 1'b0;
    bus.done = 1'b0;
    check_eq("clr_valid", 32'(bus.result_valid), 32'd0);
    check_eq("clr_result", 32'(bus.result), 32'd0);
    check_eq("clr_z_flag", 32'(bus.z_flag), 32'd1);

`ifdef MUL_SIGNED_EN
    do_load(8'hFB, 8'd3);
    run_iters(steps);
    do_done();
    check_eq("s_neg5x3_result", 32'(bus.result), 32'hFFF1);
    check_eq("s_neg5x3_sign", 32'(bus.sign), 32'd1);
    do_load(8'h80, 8'hFF);
    run_iters(steps);
    do_done();
    check_eq("s_m128xm1_result", 32'(bus.result), 32'h0080);
    check_eq("s_m128xm1_sign", 32'(bus.sign), 32'd0);
    do_load(8'hFB, 8'd0);
    do_done();
    check_eq("s_zero_sign", 32'(bus.sign), 32'd0);
`else
    // Unsigned build: 251 x 3 = 753
    do_load(8'hFB, 8'd3);
    run_iters(steps);
    do_done();
    check_eq("u251x3_result", 32'(bus.result), 32'h02F1);
    check_eq("u251x3_sign", 32'(bus.sign), 32'd0);
`endif

    // Asynchronous reset mid-iteration with a nonzero result on display
    set_sel(DIG0);
    do_load(8'd13, 8'd11);
    for (int i = 0; i < 2; i++) begin
      bus.enable = 1'b1;
      bus.Psel   = bus.b0;
      tick();
    end
    bus.enable = 1'b0;
    bus.Psel   = 1'b0;
    check_eq("pre_arst_z", 32'(bus.z_flag), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("arst_z_flag", 32'(bus.z_flag), 32'd1);
    check_eq("arst_b0", 32'(bus.b0), 32'd0);
    check_eq("arst_result", 32'(bus.result), 32'd0);
    check_eq("arst_valid", 32'(bus.result_valid), 32'd0);
    check_eq("arst_sign", 32'(bus.sign), 32'd0);
    check_eq("arst_digit", 32'(bus.digit), 32'd0);
    rst = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_datapath.md
Name: mult_datapath

Overview:
- Shift-add multiplier datapath that sits on the far side of the control unit (CU) interface.
- Consumes the CU's control strobes: load, enable, Psel, sel_1/sel_2, done and its synchronous clear.
- Returns the status bits the CU branches on: z_flag and b0.
- Holds operands, the running product and the latched result, and presents one selected nibble of the result for the seven-segment path.

Parameters:
- WIDTH, 8, operand width; product is 2*WIDTH bits; legal range 4..8.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (one clock domain)
- clr  input  1  synchronous clear from CU rst output; active-high
- a_in  input  WIDTH  multiplicand operand (switches)
- b_in  input  WIDTH  multiplier operand (switches)
- load  input  1  capture operands, clear running product
- enable  input  1  perform one shift-add iteration
- Psel  input  1  during enable: 1 = add multiplicand into product, 0 = no add
- sel_1  input  1  digit select MSB
- sel_2  input  1  digit select LSB
- done  input  1  latch final result
- z_flag  output  1  multiplier register == 0
- b0  output  1  multiplier register bit 0
- result  output  2*WIDTH  latched product
- result_valid  output  1  result holds a completed product
- sign  output  1  result sign (0 unless MUL_SIGNED_EN)
- digit  output  4  nibble {sel_1,sel_2} of result

Behaviour:
- Registers:
  - mcand: 2*WIDTH bits.
  - mplier: WIDTH bits.
  - acc: 2*WIDTH bits.
  - result: 2*WIDTH bits.
  - result_valid: 1 bit.
  - sign_r: 1 bit.
- Reset (rst=0, asynchronous): all registers 0. Consequently z_flag=1, b0=0, result=0, result_valid=0, sign=0, digit=0.
- Priority each clock edge: clr > load > enable > done. Only the highest-priority active strobe takes effect.
- clr: same register values as reset, applied synchronously.
- load:
  - mcand <= zero-extended a_in.
  - mplier <= b_in.
  - acc <= 0.
  - result_valid <= 0.
  - result keeps its old value.
- enable, with mplier != 0:
  - acc <= acc + (Psel ? mcand : 0).
  - mcand <= mcand << 1.
  - mplier <= mplier >> 1.
  - The sum is modulo 2^(2*WIDTH); it cannot overflow for legal operands.
- enable with mplier == 0: no register changes (idempotent idle step).
- Psel outside enable: ignored.
- done:
  - result <= acc (after sign fix, see option).
  - result_valid <= 1.
  - sign <= sign_r.
- z_flag and b0 are combinational from mplier. They are valid the cycle after load or enable, so the CU samples them one cycle after issuing the strobe.
- Iteration count equals the index of the highest set bit of b_in plus 1. Operand 0 gives z_flag=1 immediately after load, and a done then yields result 0.
- digit:
  - Combinational: result[4*{sel_1,sel_2} +: 4].
  - Nibbles above 2*WIDTH read 0 (e.g. WIDTH=4, sel=3 gives 0).
  - Tracks sel changes in the same cycle.
- load during an in-flight multiply: the multiply is abandoned, the new operands are taken, and the previous result stays visible.
- done without any preceding load latches the current acc (0 after reset).

Optional Feature:
- Macro: MUL_SIGNED_EN.
- Defined: operands are two's complement.
  - On load, mcand and mplier take |a_in| and |b_in| (magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), fits unsigned).
  - sign_r <= a_in[MSB] ^ b_in[MSB].
  - On done, result <= sign_r ? -acc : acc, and sign <= sign_r.
  - A zero product forces sign=0.
- Undefined: unsigned operands; sign_r and the sign output are constant 0; no negation logic is generated.

Decomposition:
- Shared package mult_pkg holds:
  - DEFAULT_WIDTH=8.
  - NIBBLE=4.
  - A digit-select encoding constant set, so the CU and display logic agree on nibble order: DIG0=2'b00 (LSN) through DIG3=2'b11.
- One natural sub-module: nibble_mux, the parameterised result-to-digit selector with zero padding. It is reusable by the display driver.

Test Plan:
- Reset: assert rst=0 mid-iteration (after 2 enables) → all outputs 0 and z_flag=1 asynchronously, before the next clk edge.
- Unsigned 13×11:
  - Stimulus: load a=13, b=11, then enable with Psel=b0 until z_flag=1 (4 steps), then done.
  - Response: result=16'h008F, result_valid=1, sign=0.
- Digit select on result 16'h008F: sel=00 → digit=F; sel=01 → 8; sel=10 → 0; sel=11 → 0.
- Zero and idle:
  - load a=200, b=0 → z_flag=1 next cycle.
  - 3 extra enables → acc unchanged.
  - done → result=0.
- Priority: load and enable in the same cycle → only load takes effect. Then clr together with done → result_valid=0, result=0.
- MUL_SIGNED_EN: a=-5 (8'hFB), b=3, run to done → result=16'hFFF1, sign=1. Separately, a=-128, b=-1 → result=16'h0080, sign=0.
